slp_layer_seq: RTL and testbench
================================

// Module: slp_layer_seq
// PURPOSE
//  Time-multiplexed sequencer for one perceptron layer of OUT neurons sharing a single slp_infer datapath.
//  - Accepts one IN-element input vector per transaction via a valid/ready handshake.
//  - Per neuron: fetches the weight+bias vector from an external weight memory and evaluates the neuron.
//  - Collects OUT results into an output vector, presented with a valid/ready handshake.
// PARAMETERS
//  IN          8            inputs per neuron
//  OUT         4            neurons in the layer (>=1)
//  I_CONF      `DEF_DCONF   input data config (dconf_t)
//  W_CONF      `DEF_DCONF   weight data config
//  O_CONF      `DEF_DCONF   output data config
//  ACT         `DEF_ACT     activation (actf_t), passed to slp_infer
//  NO_ACC_EXT  `Disable     passed to slp_infer
//  I_PREC/W_PREC/O_PREC     derived from *_CONF.prec
//  WEIGHT      IN+1         weights per neuron, bias last
//  WA          max(1,$clog2(OUT))   weight address width
// PORTS
//  clk       in   1                   clock
//  reset_    in   1                   asynchronous active-low reset
//  in_valid  in   1                   input vector valid
//  in_ready  out  1                   sequencer can accept input
//  in        in   IN*I_PREC           input vector, packed [IN-1:0][I_PREC-1:0]
//  w_rd      out  1                   weight memory read strobe
//  w_addr    out  WA                  neuron index to read
//  w_rdata   in   WEIGHT*W_PREC       weight vector; valid exactly 1 cycle after w_rd
//  out_valid out  1                   output vector valid
//  out_ready in   1                   consumer accepts output
//  out       out  OUT*O_PREC          results, [OUT-1:0][O_PREC-1:0], neuron n at index n
//  udf/ovf/rounded out 1 each          sticky OR of slp_infer flags over all neurons in the transaction
//  busy      out  1                   state != IDLE
// BEHAVIOUR
//  - Reset (async, reset_=0): state=IDLE, idx=0, in register=0, out=0; in_ready=1 after release.
//    out_valid=0, w_rd=0, w_addr=0, flags=0, busy=0.
//  - States and transitions:
//    IDLE->FETCH when in_valid&&in_ready: latch in, clear flags, idx=0.
//    FETCH: w_rd=1, w_addr=idx; ->CALC.
//    CALC: w_rdata feeds slp_infer together with the latched input.
//      Register out[idx]; OR flags into sticky regs.
//      idx==OUT-1 -> DONE; else idx++, ->FETCH.
//    DONE: out_valid=1; ->IDLE on out_ready.
//  - in_ready = (state==IDLE); in_valid in any other state is ignored and not stored.
//  - Latency: accept edge T -> out_valid high from cycle T+2*OUT+1.
//    Throughput: one vector per 2*OUT+2 cycles with out_ready tied high.
//  - out, out_valid and flags are stable while out_valid&&!out_ready.
//    out holds its last value after the handshake until overwritten neuron-by-neuron.
//  - w_rd is high only in FETCH. w_addr holds idx in all states and never exceeds OUT-1 (no wrap).
//  - Arithmetic and width rules (extended accumulate, bias const1, precision conversion) belong to slp_infer; the sequencer adds no arithmetic.
//  - OUT=1: WA=1, single FETCH/CALC pair, w_addr always 0.
//  - reset_ asserted mid-transaction: partial results and flags are discarded, return to IDLE; no w_rd afterwards.
//  - DONE with out_ready=1 and in_valid=1 in the same cycle: output completes; the input is not accepted (in_ready=0) until the next cycle in IDLE.
// STRUCTURE
//  - perceptron.svh holds dconf_t, actf_t and DEF_* macros, and gains slp_seq_state_t {IDLE,FETCH,CALC,DONE}.
//  - Single sub-module: slp_infer, instantiated once.
//  - Inside this file: FSM, idx counter, input latch, output register bank, sticky flags.
// TESTING (INT, signed, I_PREC=W_PREC=8, O_PREC=8, IN=2, OUT=2, ACT=ReLU)
//  1. Basic: in={3,-2}; mem n0={1,2,b4}, n1={-1,0,b0}.
//     -> out[0]=3, out[1]=0, flags=0.
//     -> out_valid at accept+5; w_addr 0 then 1, one w_rd each.
//  2. Backpressure: out_ready=0 for 10 cycles after out_valid.
//     -> out/flags stable; in_ready=0; extra in_valid pulses dropped.
//     -> accepted on out_ready=1; IDLE next cycle.
//  3. Back-to-back: in_valid held with new vector {1,1}, out_ready=1.
//     -> second accept 6 cycles after first; out[0]=7, out[1]=-1 clipped by ReLU to 0.
//  4. Overflow: in={127,127}, n0={127,127,b127}, NO_ACC_EXT=`Enable.
//     -> ovf=1 sticky through DONE; ovf cleared on next accept.
//  5. Reset mid-op: reset_=0 during CALC of idx 0.
//     -> all outputs 0 at once; no further w_rd; next vector computes correctly.
//  6. OUT=1 variant: single neuron {2,3,b-1}, in={1,1} -> out=4 at accept+3; w_addr=0.

Source files
------------

// File: rtl/slp_layer_seq_pkg.sv
// rtl/slp_layer_seq_pkg.sv - shared types and defaults for the layer sequencer and its neuron datapath
package slp_layer_seq_pkg;

   typedef struct packed {
      logic       sgn;
      logic [7:0] prec;
      logic [7:0] frac;
   } dconf_t;

   typedef enum logic [1:0] {ACT_NONE, ACT_RELU} actf_t;

   typedef enum logic [1:0] {IDLE, FETCH, CALC, DONE} slp_seq_state_t;

   localparam dconf_t DEF_DCONF = '{sgn: 1'b1, prec: 8'd8, frac: 8'd0};
   localparam actf_t  DEF_ACT   = ACT_RELU;
   localparam logic   DISABLE   = 1'b0;
   localparam logic   ENABLE    = 1'b1;

endpackage

// File: rtl/slp_layer_seq_infer.sv
// rtl/slp_layer_seq_infer.sv - combinational single-neuron evaluation: dot product, bias, rescale, activation, saturation
module slp_infer
   import slp_layer_seq_pkg::*;
#(
   parameter int     IN         = 8,
   parameter dconf_t I_CONF     = DEF_DCONF,
   parameter dconf_t W_CONF     = DEF_DCONF,
   parameter dconf_t O_CONF     = DEF_DCONF,
   parameter actf_t  ACT        = DEF_ACT,
   parameter logic   NO_ACC_EXT = DISABLE,
   localparam int    I_PREC     = int'(I_CONF.prec),
   localparam int    W_PREC     = int'(W_CONF.prec),
   localparam int    O_PREC     = int'(O_CONF.prec)
)(
   input  logic [IN-1:0][I_PREC-1:0] in,
   input  logic [IN:0][W_PREC-1:0]   w,
   output logic [O_PREC-1:0]         out,
   output logic                      udf,
   output logic                      ovf,
   output logic                      rounded
);
   localparam int XI = I_PREC + 1;
   localparam int XW = W_PREC + 1;
   localparam int AW = XI + XW + $clog2(IN + 1);
   localparam int NW = I_PREC + W_PREC;
   localparam int SH_RAW = int'(I_CONF.frac) + int'(W_CONF.frac) - int'(O_CONF.frac);
   localparam int SH = (SH_RAW > 0) ? SH_RAW : 0;
   localparam longint OMAX_L = O_CONF.sgn ? (64'sd1 <<< (O_PREC - 1)) - 64'sd1 : (64'sd1 <<< O_PREC) - 64'sd1;
   localparam longint OMIN_L = O_CONF.sgn ? -(64'sd1 <<< (O_PREC - 1)) : 64'sd0;
   localparam logic signed [AW-1:0] OMAX = AW'(OMAX_L);
   localparam logic signed [AW-1:0] OMIN = AW'(OMIN_L);

   logic signed [XI-1:0]    xi;
   logic signed [XW-1:0]    xw;
   logic signed [XI+XW-1:0] prod;
   logic signed [AW-1:0]    p_ext, acc_w, acc, shf, act_v;
   logic signed [NW-1:0]    acc_n;
   logic        [AW-1:0]    rmask;
   logic                    acc_ovf, sat_ovf;

   always_comb begin
      xi    = '0;
      xw    = '0;
      prod  = '0;
      p_ext = '0;
      acc_w = '0;
      // Operands widened by one bit so signed and unsigned configs share one multiplier.
      for (int i = 0; i < IN; i++) begin
         xi    = {I_CONF.sgn & in[i][I_PREC-1], in[i]};
         xw    = {W_CONF.sgn & w[i][W_PREC-1], w[i]};
         prod  = xi * xw;
         p_ext = prod;
         acc_w = acc_w + p_ext;
      end
      xw    = {W_CONF.sgn & w[IN][W_PREC-1], w[IN]};
      p_ext = xw;
      acc_w = acc_w + (p_ext <<< I_CONF.frac);

      acc_n   = acc_w[NW-1:0];
      acc     = acc_w;
      acc_ovf = 1'b0;
      if (NO_ACC_EXT) begin
         acc     = acc_n;
         acc_ovf = (acc != acc_w);
      end

      shf     = acc >>> SH;
      rmask   = ~({AW{1'b1}} << SH);
      rounded = |(acc & rmask);
      udf     = (acc != '0) && (shf == '0);

      act_v = shf;
      if (ACT == ACT_RELU && shf[AW-1]) act_v = '0;

      sat_ovf = 1'b0;
      out     = act_v[O_PREC-1:0];
      if (act_v > OMAX) begin
         out     = OMAX[O_PREC-1:0];
         sat_ovf = 1'b1;
      end else if (act_v < OMIN) begin
         out     = OMIN[O_PREC-1:0];
         sat_ovf = 1'b1;
      end
      ovf = sat_ovf | acc_ovf;
   end

endmodule

// File: rtl/slp_layer_seq.sv
// rtl/slp_layer_seq.sv - time-multiplexes one slp_infer datapath across the OUT neurons of a layer
module slp_layer_seq
   import slp_layer_seq_pkg::*;
#(
   parameter int     IN         = 8,
   parameter int     OUT        = 4,
   parameter dconf_t I_CONF     = DEF_DCONF,
   parameter dconf_t W_CONF     = DEF_DCONF,
   parameter dconf_t O_CONF     = DEF_DCONF,
   parameter actf_t  ACT        = DEF_ACT,
   parameter logic   NO_ACC_EXT = DISABLE,
   localparam int    I_PREC     = int'(I_CONF.prec),
   localparam int    W_PREC     = int'(W_CONF.prec),
   localparam int    O_PREC     = int'(O_CONF.prec),
   localparam int    WEIGHT     = IN + 1,
   localparam int    WA         = (OUT > 1) ? $clog2(OUT) : 1
)(
   input  logic                             clk,
   input  logic                             reset_,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [IN-1:0][I_PREC-1:0]        in,
   output logic                             w_rd,
   output logic [WA-1:0]                    w_addr,
   input  logic [WEIGHT-1:0][W_PREC-1:0]    w_rdata,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [OUT-1:0][O_PREC-1:0]       out,
   output logic                             udf,
   output logic                             ovf,
   output logic                             rounded,
   output logic                             busy
);
   slp_seq_state_t              state_q, state_d;
   logic [WA-1:0]               idx_q, idx_d;
   logic [IN-1:0][I_PREC-1:0]   in_q, in_d;
   logic [OUT-1:0][O_PREC-1:0]  out_q, out_d;
   logic [2:0]                  flg_q, flg_d;
   logic [O_PREC-1:0]           n_out;
   logic                        n_udf, n_ovf, n_rnd;

   slp_infer #(
      .IN(IN), .I_CONF(I_CONF), .W_CONF(W_CONF), .O_CONF(O_CONF),
      .ACT(ACT), .NO_ACC_EXT(NO_ACC_EXT)
   ) u_infer (
      .in(in_q), .w(w_rdata), .out(n_out),
      .udf(n_udf), .ovf(n_ovf), .rounded(n_rnd)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      in_d    = in_q;
      out_d   = out_q;
      flg_d   = flg_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               in_d    = in;
               idx_d   = '0;
               flg_d   = '0;
               state_d = FETCH;
            end
         end
         FETCH: state_d = CALC;
         CALC: begin
            // w_rdata returns one cycle after w_rd, so this cycle sees neuron idx_q's weights.
            out_d[idx_q] = n_out;
            flg_d        = flg_q | {n_udf, n_ovf, n_rnd};
            if (idx_q == WA'(OUT - 1)) begin
               state_d = DONE;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = FETCH;
            end
         end
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state_q <= IDLE;
         idx_q   <= '0;
         in_q    <= '0;
         out_q   <= '0;
         flg_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         in_q    <= in_d;
         out_q   <= out_d;
         flg_q   <= flg_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign w_rd      = (state_q == FETCH);
   assign w_addr    = idx_q;
   assign out_valid = (state_q == DONE);
   assign out       = out_q;
   assign udf       = flg_q[2];
   assign ovf       = flg_q[1];
   assign rounded   = flg_q[0];
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_slp_layer_seq.sv
// tb/tb_slp_layer_seq.sv - directed vector table plus hand sequences for the layer sequencer
module tb_slp_layer_seq;
   import slp_layer_seq_pkg::*;

   logic clk = 1'b0;
   logic reset_;
   always #5 clk = ~clk;

   logic             in_valid, in_ready, w_rd, out_valid, out_ready, udf, ovf, rounded, busy;
   logic [1:0][7:0]  in_v, out_w;
   logic [0:0]       w_addr;
   logic [2:0][7:0]  w_rdata;
   logic [2:0][7:0]  mem [2];

   logic             in_valid1, in_ready1, w_rd1, out_valid1, out_ready1, udf1, ovf1, rnd1, busy1;
   logic [1:0][7:0]  in_v1;
   logic [0:0]       w_addr1;
   logic [2:0][7:0]  w_rdata1, mem1;
   logic [0:0][7:0]  out1;

   slp_layer_seq #(.IN(2), .OUT(2), .ACT(ACT_RELU), .NO_ACC_EXT(ENABLE)) dut (
      .clk(clk), .reset_(reset_), .in_valid(in_valid), .in_ready(in_ready), .in(in_v),
      .w_rd(w_rd), .w_addr(w_addr), .w_rdata(w_rdata), .out_valid(out_valid),
      .out_ready(out_ready), .out(out_w), .udf(udf), .ovf(ovf), .rounded(rounded), .busy(busy)
   );

   slp_layer_seq #(.IN(2), .OUT(1), .ACT(ACT_RELU), .NO_ACC_EXT(DISABLE)) dut1 (
      .clk(clk), .reset_(reset_), .in_valid(in_valid1), .in_ready(in_ready1), .in(in_v1),
      .w_rd(w_rd1), .w_addr(w_addr1), .w_rdata(w_rdata1), .out_valid(out_valid1),
      .out_ready(out_ready1), .out(out1), .udf(udf1), .ovf(ovf1), .rounded(rnd1), .busy(busy1)
   );

   int rd_cnt = 0, rd1 = 0;
   int addr_log [8];
   int a1log = -1;

   always @(posedge clk) begin
      if (w_rd) begin
         if (rd_cnt < 8) addr_log[rd_cnt] = int'(w_addr);
         rd_cnt++;
         w_rdata <= mem[w_addr];
      end
      if (w_rd1) begin
         rd1++;
         a1log = int'(w_addr1);
         w_rdata1 <= mem1;
      end
   end

   int n_cmp = 0, n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d required %0d", name, $signed(act), $signed(exp));
      end
   endtask

   function automatic logic [1:0][7:0] pk(input int a0, input int a1);
      logic [1:0][7:0] r;
      r[0] = a0[7:0];
      r[1] = a1[7:0];
      return r;
   endfunction

   function automatic logic [2:0][7:0] pk3(input int x0, input int x1, input int b);
      logic [2:0][7:0] r;
      r[0] = x0[7:0];
      r[1] = x1[7:0];
      r[2] = b[7:0];
      return r;
   endfunction

   // Accept one vector and return the cycle count (accept cycle = 0) until out_valid.
   task automatic do_txn(input string tag, input int a0, input int a1, output int lat);
      @(negedge clk);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      in_v     = pk(a0, a1);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat      = 1;
      while (!out_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic release_out(input string tag);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   typedef struct {
      int   a0, a1;
      int   w00, w01, b0;
      int   w10, w11, b1;
      int   e0, e1;
      logic eovf;
   } vec_t;

   vec_t tbl [5];

   initial begin
      int lat, a1, a2;

      tbl[0] = '{3, -2, 1, 2, 4, -1, 0, 0, 3, 0, 1'b0};
      tbl[1] = '{1, 1, 1, 2, 4, -1, 0, 0, 7, 0, 1'b0};
      tbl[2] = '{127, 127, 127, 127, 127, -1, 0, 0, 127, 0, 1'b1};
      tbl[3] = '{10, -20, 5, 5, -3, -5, -5, 2, 0, 52, 1'b0};
      tbl[4] = '{-128, -128, -128, -128, 0, 1, 1, 0, 0, 0, 1'b1};

      reset_ = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0; in_v = '0;
      in_valid1 = 1'b0; out_ready1 = 1'b0; in_v1 = '0;
      mem[0] = '0; mem[1] = '0; mem1 = '0;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_w_rd", 32'(w_rd), 32'd0);
      chk("rst_w_addr", 32'(w_addr), 32'd0);
      chk("rst_out", 32'(out_w), 32'd0);
      chk("rst_flags", 32'({udf, ovf, rounded}), 32'd0);
      reset_ = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      for (int v = 0; v < 5; v++) begin
         string t;
         t = $sformatf("vec%0d", v);
         mem[0] = pk3(tbl[v].w00, tbl[v].w01, tbl[v].b0);
         mem[1] = pk3(tbl[v].w10, tbl[v].w11, tbl[v].b1);
         rd_cnt = 0;
         do_txn(t, tbl[v].a0, tbl[v].a1, lat);
         chk({t, "_latency"}, 32'(lat), 32'd5);
         chk({t, "_out0"}, 32'($signed(out_w[0])), 32'(tbl[v].e0));
         chk({t, "_out1"}, 32'($signed(out_w[1])), 32'(tbl[v].e1));
         chk({t, "_ovf"}, 32'(ovf), 32'(tbl[v].eovf));
         chk({t, "_udf_rnd"}, 32'({udf, rounded}), 32'd0);
         chk({t, "_rd_cnt"}, 32'(rd_cnt), 32'd2);
         chk({t, "_addr0"}, 32'(addr_log[0]), 32'd0);
         chk({t, "_addr1"}, 32'(addr_log[1]), 32'd1);
         release_out(t);
      end

      // Backpressure: hold results while in_valid pulses are ignored.
      mem[0] = pk3(1, 2, 4);
      mem[1] = pk3(-1, 0, 0);
      rd_cnt = 0;
      do_txn("bp", 3, -2, lat);
      chk("bp_latency", 32'(lat), 32'd5);
      for (int c = 0; c < 10; c++) begin
         in_v     = pk(9, 9);
         in_valid = c[0];
         @(negedge clk);
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_out", 32'(out_w), 32'h0003);
      end
      in_valid = 1'b0;
      release_out("bp");
      chk("bp_in_ready_after", 32'(in_ready), 32'd1);
      chk("bp_out_held", 32'(out_w), 32'h0003);
      chk("bp_rd_cnt", 32'(rd_cnt), 32'd2);

      // Back-to-back with in_valid held and out_ready high.
      @(negedge clk);
      in_v = pk(3, -2); in_valid = 1'b1; out_ready = 1'b1;
      a1 = -1; a2 = -1;
      for (int c = 0; c < 40 && a2 < 0; c++) begin
         if (out_valid) begin
            chk("b2b_done_in_ready", 32'(in_ready), 32'd0);
            chk("b2b_first_out", 32'(out_w), 32'h0003);
         end
         if (in_ready && in_valid) begin
            if (a1 < 0) a1 = c;
            else a2 = c;
         end
         @(negedge clk);
         if (a1 >= 0) in_v = pk(1, 1);
      end
      in_valid = 1'b0;
      chk("b2b_gap", 32'(a2 - a1), 32'd6);
      lat = 1;
      while (!out_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      chk("b2b_latency", 32'(lat), 32'd5);
      chk("b2b_out0", 32'($signed(out_w[0])), 32'd7);
      chk("b2b_out1", 32'($signed(out_w[1])), 32'd0);
      out_ready = 1'b0;
      @(negedge clk);

      // Reset asserted during CALC of neuron 0.
      in_v = pk(3, -2); in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk("mid_busy", 32'(busy), 32'd1);
      reset_ = 1'b0;
      #1;
      chk("mid_out", 32'(out_w), 32'd0);
      chk("mid_out_valid", 32'(out_valid), 32'd0);
      chk("mid_busy_rst", 32'(busy), 32'd0);
      chk("mid_w_rd", 32'(w_rd), 32'd0);
      chk("mid_w_addr", 32'(w_addr), 32'd0);
      rd_cnt = 0;
      repeat (3) @(negedge clk);
      reset_ = 1'b1;
      repeat (4) @(negedge clk);
      chk("mid_no_rd", 32'(rd_cnt), 32'd0);
      do_txn("post_rst", 3, -2, lat);
      chk("post_rst_latency", 32'(lat), 32'd5);
      chk("post_rst_out", 32'(out_w), 32'h0003);
      release_out("post_rst");

      // Single-neuron instance.
      mem1 = pk3(2, 3, -1);
      rd1 = 0;
      @(negedge clk);
      chk("one_in_ready", 32'(in_ready1), 32'd1);
      in_v1 = pk(1, 1); in_valid1 = 1'b1;
      @(negedge clk);
      in_valid1 = 1'b0;
      lat = 1;
      while (!out_valid1 && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      chk("one_latency", 32'(lat), 32'd3);
      chk("one_out", 32'($signed(out1[0])), 32'd4);
      chk("one_w_addr", 32'(w_addr1), 32'd0);
      chk("one_rd_cnt", 32'(rd1), 32'd1);
      chk("one_rd_addr", 32'(a1log), 32'd0);
      chk("one_ovf", 32'(ovf1), 32'd0);
      out_ready1 = 1'b1;
      @(negedge clk);
      out_ready1 = 1'b0;
      chk("one_idle", 32'(busy1), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
